wired_bus_resolver: RTL and testbench
=====================================

# wired_bus_resolver

Multi-driver bus front end that feeds wired net resolution. It arbitrates `NDRV` drivers round-robin and resolves each accepted beat from the owner plus any co-driving agents. Resolution is plain wire (exclusive), wired-AND (wand) or wired-OR (wor). The result goes into a registered valid/ready output, and co-driver conflicts are flagged. It sits directly upstream of the resolved-net consumers and produces the value those nets would carry.

## Interface
Parameters:
- `NDRV`, 4, number of drivers (2..16)
- `WIDTH`, 4, bus data width
- `MODE`, `MODE_WIRE`, resolution mode from `wired_bus_pkg`: `MODE_WIRE`, `MODE_WAND` or `MODE_WOR`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous and active-high
- `drv_req`  in  NDRV  driver i requests bus ownership / presents a beat
- `drv_en`  in  NDRV  driver i actively drives `drv_data` this cycle (co-drive)
- `drv_data`  in  NDRV*WIDTH  driver i data in slice [i*WIDTH +: WIDTH]
- `drv_last`  in  NDRV  beat from driver i is its final beat
- `grant`  out  NDRV  one-hot registered owner, 0 when idle
- `drv_ack`  out  NDRV  combinational, owner's beat accepted this cycle
- `bus_valid`  out  1  output register holds a beat
- `bus_data`  out  WIDTH  resolved beat
- `bus_ready`  in  1  downstream accepts
- `conflict`  out  1  registered, set with a beat whose drivers disagreed
- `conflict_cnt`  out  8  saturating conflict count

## Operation
- FSM states: `IDLE`, `BUSY`.
- `IDLE`:
  - If any `drv_req` is set, pick the first requester after `last_owner` (rotating, wraps NDRV-1 -> 0).
  - Register the one-hot pick into `grant` and go to `BUSY`.
  - With no request, stay in `IDLE` with `grant` = 0.
- `BUSY`:
  - `space = !bus_valid || bus_ready`.
  - `drv_ack = grant & drv_req & {NDRV{space}}`.
  - On ack, capture `resolve()` into `bus_data` and set `bus_valid`.
  - If the owner's `drv_last` is set with the ack: `grant` <= 0, `last_owner` <= owner, go to `IDLE`.
  - An owner dropping `drv_req` mid-ownership stalls; it does not release.
- Contributors = owner plus every i with `drv_en[i]`.
- `resolve()`:
  - `MODE_WIRE`: owner's data only.
  - `MODE_WAND`: bitwise AND over contributors.
  - `MODE_WOR`: bitwise OR over contributors.
- Conflict is set on the captured beat when any non-owner contributor exists and its data differs from the owner's data, in any mode.
  - `conflict` updates only on capture.
  - `conflict_cnt` increments by 1 per conflicting capture and saturates at 255.
- `bus_valid` clears when `bus_ready` is high and no new capture happens in the same cycle.
- Simultaneous accept and capture: the register is overwritten, no bubble.
- Reset mid-ownership: the beat in flight is dropped, `grant` returns to 0, and `last_owner` returns to NDRV-1 so driver 0 has first priority.

## Timing
- Reset values: `grant` 0, `bus_valid` 0, `bus_data` 0, `conflict` 0, `conflict_cnt` 0, state `IDLE`, `last_owner` NDRV-1.
- Request to grant: 1 cycle.
- Ack to `bus_valid`: 1 cycle.
- Throughput: 1 beat/cycle with `bus_ready` held high.
- Release to next grant: minimum 1 idle cycle.
- `bus_data` is stable while `bus_valid && !bus_ready`.
- `drv_ack` never asserts in `IDLE`.

## Configuration
- `WIRED_BUS_CONFLICT_CNT_EN` defined: the counter is implemented as above.
- Macro undefined: `conflict_cnt` is tied to 0 and no counter flops exist. The `conflict` flag is unaffected.

## Structure
- Package `wired_bus_pkg` holds:
  - the `mode_e` enum (`MODE_WIRE`, `MODE_WAND`, `MODE_WOR`)
  - the `state_e` enum (`IDLE`, `BUSY`)
  - the `CONFLICT_CNT_W` = 8 constant
- Sub-module `rr_pick`: combinational round-robin selector (req vector and last_owner in, one-hot and index out).
- Resolution and the FSM stay in the top module.

## Test plan
- MODE_WIRE, driver 2 alone, beat 4'b1001 with last, `bus_ready` high -> `grant` = 4'b0100 after 1 cycle, `bus_data` = 4'b1001, `conflict` = 0, `grant` clears after last.
- MODE_WAND, owner 0 data 4'b1001, driver 1 `drv_en` data 4'b1010 -> `bus_data` = 4'b1000, `conflict` = 1, `conflict_cnt` = 1.
- MODE_WOR, same stimulus -> `bus_data` = 4'b1011. Same stimulus with equal data 4'b1001 -> `bus_data` = 4'b1001, `conflict` = 0.
- All four drivers requesting, single-beat transfers -> grant order 0, 1, 2, 3, 0, with one idle cycle between grants.
- Backpressure: `bus_ready` low for 3 cycles while the owner presents 3 beats -> only the first beat captured, `drv_ack` low, `bus_data` stable. Release `bus_ready` -> beats appear in order with no loss.
- `rst` asserted in `BUSY` with `bus_valid` = 1 -> next cycle all outputs are at reset values, and the next request from drivers 0 and 3 grants driver 0.

Source files
------------

// File: rtl/wired_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wired_bus_pkg                                                              |
// | Shared types and constants for the wired bus resolver.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wired_bus_pkg;

    typedef enum logic [1:0] {
        MODE_WIRE = 2'd0,
        MODE_WAND = 2'd1,
        MODE_WOR  = 2'd2
    } mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int CONFLICT_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/wired_bus_resolver_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Combinational round-robin selector: first requester after last_owner.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic w_found;

    // Upper segment (above last_owner) first, then wrap to the lower segment.
    always_comb begin
        onehot  = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (IW'(i) > last_owner)) begin
                onehot[i] = 1'b1;
                idx       = IW'(i);
                w_found   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (IW'(i) <= last_owner)) begin
                onehot[i] = 1'b1;
                idx       = IW'(i);
                w_found   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/wired_bus_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wired_bus_resolver                                                         |
// | Round-robin multi-driver bus with wire/wand/wor resolution and conflict    |
// | flagging. Optional counter: define WIRED_BUS_CONFLICT_CNT_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wired_bus_resolver
    import wired_bus_pkg::*;
#(
    parameter int    NDRV  = 4,
    parameter int    WIDTH = 4,
    parameter mode_e MODE  = MODE_WIRE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NDRV-1:0]           drv_req,
    input  logic [NDRV-1:0]           drv_en,
    input  logic [NDRV*WIDTH-1:0]     drv_data,
    input  logic [NDRV-1:0]           drv_last,
    output logic [NDRV-1:0]           grant,
    output logic [NDRV-1:0]           drv_ack,
    output logic                      bus_valid,
    output logic [WIDTH-1:0]          bus_data,
    input  logic                      bus_ready,
    output logic                      conflict,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    localparam int IW = (NDRV > 1) ? $clog2(NDRV) : 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [NDRV-1:0]   r_grant;
    logic [NDRV-1:0]   w_grant_nxt;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     w_owner_nxt;
    logic [IW-1:0]     r_last_owner;
    logic [IW-1:0]     w_last_owner_nxt;

    logic [NDRV-1:0]   w_pick_onehot;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;

    logic              w_space;
    logic              w_capture;
    logic              w_release;

    logic [WIDTH-1:0]  w_owner_data;
    logic [WIDTH-1:0]  w_and;
    logic [WIDTH-1:0]  w_or;
    logic [WIDTH-1:0]  w_resolved;
    logic              w_conflict;

    logic              r_bus_valid;
    logic [WIDTH-1:0]  r_bus_data;
    logic              r_conflict;

    rr_pick #(
        .N  (NDRV),
        .IW (IW)
    ) u_rr_pick (
        .req        (drv_req),
        .last_owner (r_last_owner),
        .onehot     (w_pick_onehot),
        .idx        (w_pick_idx),
        .any        (w_pick_any)
    );

    assign w_space   = !r_bus_valid || bus_ready;
    assign drv_ack   = (r_state == BUSY) ? (r_grant & drv_req & {NDRV{w_space}}) : '0;
    assign w_capture = |drv_ack;
    assign w_release = |(drv_ack & drv_last);

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick_onehot;
                    w_owner_nxt = w_pick_idx;
                end
            end
            BUSY: begin
                // Ownership ends only on an accepted last beat; a dropped req just stalls.
                if (w_release) begin
                    w_state_nxt      = IDLE;
                    w_grant_nxt      = '0;
                    w_last_owner_nxt = r_owner;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IW'(NDRV - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Contributors are the owner plus every co-driver with drv_en set.
    always_comb begin
        w_owner_data = '0;
        w_and        = '1;
        w_or         = '0;
        w_conflict   = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (r_grant[i]) begin
                w_owner_data = drv_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NDRV; i++) begin
            if (r_grant[i] || drv_en[i]) begin
                w_and = w_and & drv_data[i*WIDTH +: WIDTH];
                w_or  = w_or  | drv_data[i*WIDTH +: WIDTH];
            end
            if (drv_en[i] && !r_grant[i] && (drv_data[i*WIDTH +: WIDTH] != w_owner_data)) begin
                w_conflict = 1'b1;
            end
        end
        case (MODE)
            MODE_WAND: w_resolved = w_and;
            MODE_WOR:  w_resolved = w_or;
            default:   w_resolved = w_owner_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_conflict  <= 1'b0;
        end else if (w_capture) begin
            r_bus_valid <= 1'b1;
            r_bus_data  <= w_resolved;
            r_conflict  <= w_conflict;
        end else if (bus_ready) begin
            r_bus_valid <= 1'b0;
        end
    end

`ifdef WIRED_BUS_CONFLICT_CNT_EN
    logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_capture && w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = '0;
`endif

    assign grant     = r_grant;
    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;
    assign conflict  = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_wired_bus_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wired_bus_resolver                                                      |
// | Scoreboard bench driving wire, wand and wor instances with shared inputs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wired_bus_resolver;
    import wired_bus_pkg::*;

    localparam int NDRV  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NDRV-1:0]       drv_req, drv_en, drv_last;
    logic [NDRV*WIDTH-1:0] drv_data;
    logic                  bus_ready;

    logic [NDRV-1:0]  grant_w, grant_a, grant_o;
    logic [NDRV-1:0]  ack_w, ack_a, ack_o;
    logic             valid_w, valid_a, valid_o;
    logic [WIDTH-1:0] data_w, data_a, data_o;
    logic             conf_w, conf_a, conf_o;
    logic [7:0]       cnt_w, cnt_a, cnt_o;

    typedef struct packed {
        logic [WIDTH-1:0] d_wire;
        logic [WIDTH-1:0] d_wand;
        logic [WIDTH-1:0] d_wor;
        logic             cf;
        logic [7:0]       cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    wired_bus_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .MODE(MODE_WIRE)) u_wire (
        .clk(clk), .rst(rst), .drv_req(drv_req), .drv_en(drv_en), .drv_data(drv_data),
        .drv_last(drv_last), .grant(grant_w), .drv_ack(ack_w), .bus_valid(valid_w),
        .bus_data(data_w), .bus_ready(bus_ready), .conflict(conf_w), .conflict_cnt(cnt_w));

    wired_bus_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .MODE(MODE_WAND)) u_wand (
        .clk(clk), .rst(rst), .drv_req(drv_req), .drv_en(drv_en), .drv_data(drv_data),
        .drv_last(drv_last), .grant(grant_a), .drv_ack(ack_a), .bus_valid(valid_a),
        .bus_data(data_a), .bus_ready(bus_ready), .conflict(conf_a), .conflict_cnt(cnt_a));

    wired_bus_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .MODE(MODE_WOR)) u_wor (
        .clk(clk), .rst(rst), .drv_req(drv_req), .drv_en(drv_en), .drv_data(drv_data),
        .drv_last(drv_last), .grant(grant_o), .drv_ack(ack_o), .bus_valid(valid_o),
        .bus_data(data_o), .bus_ready(bus_ready), .conflict(conf_o), .conflict_cnt(cnt_o));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [WIDTH-1:0] d);
        logic [NDRV*WIDTH-1:0] mask;
        mask     = (NDRV*WIDTH)'({WIDTH{1'b1}}) << (idx*WIDTH);
        drv_data = (drv_data & ~mask) | ((NDRV*WIDTH)'(d) << (idx*WIDTH));
    endtask

    // Expected beat from the current driver inputs with the given owner.
    task automatic push_beat(input int owner);
        exp_t             e;
        logic [WIDTH-1:0] od, s;
        od       = WIDTH'(drv_data >> (owner*WIDTH));
        e.d_wire = od;
        e.d_wand = od;
        e.d_wor  = od;
        e.cf     = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (drv_en[i] && (i != owner)) begin
                s        = WIDTH'(drv_data >> (i*WIDTH));
                e.d_wand = e.d_wand & s;
                e.d_wor  = e.d_wor | s;
                if (s != od) e.cf = 1'b1;
            end
        end
`ifdef WIRED_BUS_CONFLICT_CNT_EN
        if (e.cf && (exp_cnt < 255)) exp_cnt++;
`endif
        e.cnt = 8'(exp_cnt);
        sb_q.push_back(e);
    endtask

    // Output side of the scoreboard: every handshake pops one expected beat.
    always @(negedge clk) begin
        if (!rst && valid_w && bus_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got beat wire=%h with empty queue, required no beat", data_w);
            end else begin
                m_e = sb_q.pop_front();
                if ({data_w, data_a, data_o, conf_w, conf_a, conf_o, cnt_w, valid_a, valid_o} !==
                    {m_e.d_wire, m_e.d_wand, m_e.d_wor, {3{m_e.cf}}, m_e.cnt, 2'b11}) begin
                    bad++;
                    $display("FAIL sb_beat: got wire=%h wand=%h wor=%h conf=%b%b%b cnt=%0d vld=%b%b, required wire=%h wand=%h wor=%h conf=%b cnt=%0d",
                             data_w, data_a, data_o, conf_w, conf_a, conf_o, cnt_w, valid_a, valid_o,
                             m_e.d_wire, m_e.d_wand, m_e.d_wor, m_e.cf, m_e.cnt);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; drv_req = '0; drv_en = '0; drv_last = '0; drv_data = '0; bus_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        total++;
        if ({grant_w, grant_a, grant_o, ack_w} !== '0) begin
            bad++; $display("FAIL reset_grant: got grant=%b ack=%b, required 0", grant_w, ack_w);
        end
        total++;
        if ({valid_w, valid_a, valid_o, conf_w, conf_a, conf_o} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got valid=%b%b%b conf=%b%b%b, required 0",
                            valid_w, valid_a, valid_o, conf_w, conf_a, conf_o);
        end
        total++;
        if ({data_w, data_a, data_o, cnt_w} !== '0) begin
            bad++; $display("FAIL reset_data: got data=%h/%h/%h cnt=%0d, required 0", data_w, data_a, data_o, cnt_w);
        end
    endtask

    task automatic test_round_robin();
        logic [NDRV-1:0] eg;
        drv_req = 4'b1111; drv_last = 4'b1111; drv_en = '0;
        for (int i = 0; i < NDRV; i++) set_data(i, WIDTH'(i + 5));
        #1;
        total++;
        if (ack_w !== '0) begin
            bad++; $display("FAIL rr_ack_idle: got ack=%b, required 0000", ack_w);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            eg = NDRV'(1) << (k % NDRV);
            total++;
            if ({grant_w, ack_w, grant_a, grant_o} !== {eg, eg, eg, eg}) begin
                bad++; $display("FAIL rr_grant%0d: got grant=%b ack=%b, required %b", k, grant_w, ack_w, eg);
            end
            push_beat(k % NDRV);
            tick();
            total++;
            if ({grant_w, ack_w} !== '0) begin
                bad++; $display("FAIL rr_gap%0d: got grant=%b ack=%b, required 0", k, grant_w, ack_w);
            end
        end
        drv_req = '0; drv_last = '0;
    endtask

    task automatic test_wire_single();
        tick();
        drv_req = 4'b0100; drv_en = '0; drv_last = 4'b0100; drv_data = '0;
        set_data(2, 4'b1001);
        tick();
        total++;
        if ({grant_w, ack_w} !== {4'b0100, 4'b0100}) begin
            bad++; $display("FAIL wire_grant: got grant=%b ack=%b, required 0100/0100", grant_w, ack_w);
        end
        push_beat(2);
        tick();
        drv_req = '0; drv_last = '0;
        #1;
        total++;
        if ({grant_w, data_w, conf_w, valid_w} !== {4'b0000, 4'b1001, 1'b0, 1'b1}) begin
            bad++; $display("FAIL wire_beat: got grant=%b data=%b conf=%b valid=%b, required 0000/1001/0/1",
                            grant_w, data_w, conf_w, valid_w);
        end
        tick();
        total++;
        if (valid_w !== 1'b0) begin
            bad++; $display("FAIL wire_valid_clear: got %b, required 0", valid_w);
        end
    endtask

    task automatic test_resolve();
        logic [7:0] ec;
`ifdef WIRED_BUS_CONFLICT_CNT_EN
        ec = 8'd1;
`else
        ec = 8'd0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            tick();
            drv_req = 4'b0001; drv_en = 4'b0010; drv_last = 4'b0001; drv_data = '0;
            set_data(0, 4'b1001);
            set_data(1, (pass == 0) ? 4'b1010 : 4'b1001);
            tick();
            total++;
            if ({grant_w, ack_w} !== {4'b0001, 4'b0001}) begin
                bad++; $display("FAIL res_grant%0d: got grant=%b ack=%b, required 0001/0001", pass, grant_w, ack_w);
            end
            push_beat(0);
            tick();
            drv_req = '0; drv_en = '0; drv_last = '0;
            #1;
            total++;
            if (pass == 0) begin
                if ({data_w, data_a, data_o, conf_w, conf_a, conf_o, cnt_a} !==
                    {4'b1001, 4'b1000, 4'b1011, 3'b111, ec}) begin
                    bad++; $display("FAIL res_conflict: got %b/%b/%b conf=%b%b%b cnt=%0d, required 1001/1000/1011 conf=111 cnt=%0d",
                                    data_w, data_a, data_o, conf_w, conf_a, conf_o, cnt_a, ec);
                end
            end else begin
                if ({data_w, data_a, data_o, conf_w, conf_a, conf_o, cnt_o} !==
                    {4'b1001, 4'b1001, 4'b1001, 3'b000, ec}) begin
                    bad++; $display("FAIL res_agree: got %b/%b/%b conf=%b%b%b cnt=%0d, required 1001 x3 conf=000 cnt=%0d",
                                    data_w, data_a, data_o, conf_w, conf_a, conf_o, cnt_o, ec);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        tick();
        bus_ready = 1'b0; drv_req = 4'b0010; drv_en = '0; drv_last = '0; drv_data = '0;
        set_data(1, 4'h3);
        tick();
        total++;
        if ({grant_w, ack_w} !== {4'b0010, 4'b0010}) begin
            bad++; $display("FAIL bp_first: got grant=%b ack=%b, required 0010/0010", grant_w, ack_w);
        end
        push_beat(1);
        tick();
        set_data(1, 4'h6);
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({ack_w, valid_w, data_w, data_a, data_o} !== {4'b0000, 1'b1, 4'h3, 4'h3, 4'h3}) begin
                bad++; $display("FAIL bp_stall%0d: got ack=%b valid=%b data=%h, required 0000/1/3", c, ack_w, valid_w, data_w);
            end
            tick();
        end
        bus_ready = 1'b1;
        #1;
        total++;
        if (ack_w !== 4'b0010) begin
            bad++; $display("FAIL bp_resume: got ack=%b, required 0010", ack_w);
        end
        push_beat(1);
        tick();
        set_data(1, 4'h9); drv_last = 4'b0010;
        #1;
        total++;
        if (ack_w !== 4'b0010) begin
            bad++; $display("FAIL bp_last: got ack=%b, required 0010", ack_w);
        end
        push_beat(1);
        tick();
        drv_req = '0; drv_last = '0;
        tick();
        tick();
        total++;
        if ({grant_w, valid_w} !== 5'b0) begin
            bad++; $display("FAIL bp_done: got grant=%b valid=%b, required 0/0", grant_w, valid_w);
        end
    endtask

    task automatic test_reset_busy();
        tick();
        bus_ready = 1'b0; drv_req = 4'b0100; drv_en = '0; drv_last = '0; drv_data = '0;
        set_data(2, 4'hC);
        tick();
        tick();
        total++;
        if ({grant_w, valid_w, data_w} !== {4'b0100, 1'b1, 4'hC}) begin
            bad++; $display("FAIL rb_setup: got grant=%b valid=%b data=%h, required 0100/1/c", grant_w, valid_w, data_w);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; exp_cnt = 0;
        drv_req = 4'b1001; drv_last = 4'b1001; bus_ready = 1'b1; drv_data = '0;
        set_data(0, 4'h1); set_data(3, 4'h2);
        #1;
        total++;
        if ({grant_w, ack_w, valid_w, valid_a, valid_o, data_w, conf_w, cnt_w} !== '0) begin
            bad++; $display("FAIL rb_reset: got grant=%b ack=%b valid=%b data=%h conf=%b cnt=%0d, required all 0",
                            grant_w, ack_w, valid_w, data_w, conf_w, cnt_w);
        end
        tick();
        total++;
        if ({grant_w, ack_w} !== {4'b0001, 4'b0001}) begin
            bad++; $display("FAIL rb_prio: got grant=%b ack=%b, required 0001/0001", grant_w, ack_w);
        end
        push_beat(0);
        tick();
        drv_req = '0; drv_last = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wire_single();
        test_resolve();
        test_backpressure();
        test_reset_busy();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_drain: got %0d beats outstanding, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
